// File: rtl/boot_seq_pkg.sv
// Shared constants for the boot sequencer: FSM state codes, the default STOP
// opcode and the word-to-byte address shifts for each memory port.
package boot_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_D = 3'd1;
  localparam state_t ST_LOAD_I = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_RUN    = 3'd4;
  localparam state_t ST_DUMP   = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  localparam logic [6:0] STOP_OPCODE_DEFAULT = 7'b1111110;

  // dmem holds 64-bit words, imem holds 32-bit words
  localparam int unsigned DMEM_SHIFT = 3;
  localparam int unsigned IMEM_SHIFT = 2;

  // Load index width; wide enough for any sensible image size
  localparam int unsigned IDX_W = 16;

  function automatic logic [63:0] word_addr(input logic [IDX_W-1:0] idx,
                                            input int unsigned      shift);
    word_addr = 64'(idx) << shift;
  endfunction

endpackage

// File: rtl/boot_seq_dump_fifo.sv
// Two-entry 64-bit valid/ready buffer for dmem read data. The credit output
// tells the issuer whether a read launched now still finds a free slot when
// its data returns one cycle later.
module boot_seq_dump_fifo
  import boot_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        inflight,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic        out_ready,
  output logic        credit
);

  logic [63:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        pop;
  logic [1:0]  committed;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  // Occupancy after this edge plus the read already in flight; a pop in the
  // cycle the new data lands is not relied on.
  assign committed = count + 2'(inflight) - 2'(pop);
  assign credit    = (committed < 2'd2);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: loads a dmem image then an imem image from a host stream,
// runs the cpu until the STOP opcode, then streams a dmem result window out.
// Optional watchdog: define BOOT_SEQ_WATCHDOG_EN to add wd_limit/timeout.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int unsigned IMEM_WORDS  = 128,
  parameter int unsigned DMEM_WORDS  = 128,
  parameter logic [6:0]  STOP_OPCODE = STOP_OPCODE_DEFAULT,
  parameter int unsigned CYCLE_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [63:0]        ld_data,
  output logic [63:0]        addr_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  output logic [31:0]        wdata_ext,
  output logic [63:0]        addr_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  output logic [63:0]        wdata_ext_2,
  input  logic [63:0]        rdata_ext_2,
  output logic               cpu_enable,
  input  logic [31:0]        instr,
  input  logic [6:0]         dump_base,
  input  logic [7:0]         dump_len,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [63:0]        dout_data,
  output logic               busy,
  output logic               done,
  output logic [3:0]         test_id,
  output logic [CYCLE_W-1:0] cycle_count
`ifdef BOOT_SEQ_WATCHDOG_EN
  ,
  input  logic [CYCLE_W-1:0] wd_limit,
  output logic               timeout
`endif
);

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic [6:0]         dump_base_q;
  logic [7:0]         dump_len_q;
  logic [7:0]         rd_cnt;
  logic [7:0]         out_cnt;
  logic               rd_pending;

  logic               wen1_q;
  logic [63:0]        addr1_q;
  logic [31:0]        wdata1_q;
  logic               wen2_q;
  logic [63:0]        addr2_q;
  logic [63:0]        wdata2_q;

  logic [3:0]         test_id_q;
  logic [CYCLE_W-1:0] cycle_q;

  logic               accept;
  logic               session_start;
  logic               stop_seen;
  logic               wd_trip;
  logic               rd_issue;
  logic               credit;
  logic               dout_fire;
  logic               dump_last;
  logic [6:0]         rd_word;
  logic               idx_last_d;
  logic               idx_last_i;

  // Only the opcode and the test-id nibble of the instruction are monitored
  logic               unused_instr;
  assign unused_instr = ^instr[27:7];

  assign ld_ready      = (state == ST_LOAD_D) || (state == ST_LOAD_I);
  assign accept        = ld_valid & ld_ready;
  assign session_start = start & ((state == ST_IDLE) || (state == ST_DONE));
  assign stop_seen     = (state == ST_RUN) && (instr[6:0] == STOP_OPCODE);
  assign idx_last_d    = (idx == IDX_W'(DMEM_WORDS - 1));
  assign idx_last_i    = (idx == IDX_W'(IMEM_WORDS - 1));

`ifdef BOOT_SEQ_WATCHDOG_EN
  logic timeout_q;
  assign wd_trip = (state == ST_RUN) && !stop_seen && (cycle_q == wd_limit);
  assign timeout = timeout_q;
`else
  assign wd_trip = 1'b0;
`endif

  // Word index wraps at 128 by virtue of the 7-bit sum
  assign rd_word   = dump_base_q + rd_cnt[6:0];
  assign rd_issue  = (state == ST_DUMP) && (rd_cnt < dump_len_q) && credit;
  assign dout_fire = dout_valid & dout_ready;
  assign dump_last = dout_fire && (out_cnt == dump_len_q - 8'd1);

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_LOAD_D;
      ST_LOAD_D: if (accept && idx_last_d) state_nx = ST_LOAD_I;
      ST_LOAD_I: if (accept && idx_last_i) state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_RUN;
      ST_RUN: begin
        if (stop_seen || wd_trip) begin
          state_nx = (dump_len_q == 8'd0) ? ST_DONE : ST_DUMP;
        end
      end
      ST_DUMP:   if (dump_last) state_nx = ST_DONE;
      ST_DONE:   if (start) state_nx = ST_LOAD_D;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Load path: each accepted beat becomes a registered write one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      wen1_q   <= 1'b0;
      addr1_q  <= '0;
      wdata1_q <= '0;
      wen2_q   <= 1'b0;
      addr2_q  <= '0;
      wdata2_q <= '0;
    end else begin
      wen1_q <= 1'b0;
      wen2_q <= 1'b0;
      if (session_start) idx <= '0;
      if (accept) begin
        if (state == ST_LOAD_D) begin
          wen2_q   <= 1'b1;
          addr2_q  <= word_addr(idx, DMEM_SHIFT);
          wdata2_q <= ld_data;
          idx      <= idx_last_d ? '0 : idx + IDX_W'(1);
        end else begin
          wen1_q   <= 1'b1;
          addr1_q  <= word_addr(idx, IMEM_SHIFT);
          wdata1_q <= ld_data[31:0];
          idx      <= idx_last_i ? '0 : idx + IDX_W'(1);
        end
      end
    end
  end

  // Session configuration, cycle counter and test id capture
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_base_q <= '0;
      dump_len_q  <= '0;
      cycle_q     <= '0;
      test_id_q   <= '0;
`ifdef BOOT_SEQ_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else if (session_start) begin
      dump_base_q <= dump_base;
      dump_len_q  <= dump_len;
      cycle_q     <= '0;
      test_id_q   <= '0;
`ifdef BOOT_SEQ_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else if (state == ST_RUN) begin
      if (stop_seen) begin
        test_id_q <= instr[31:28];
      end else if (wd_trip) begin
        test_id_q <= 4'hF;
`ifdef BOOT_SEQ_WATCHDOG_EN
        timeout_q <= 1'b1;
`endif
      end else if (cycle_q != {CYCLE_W{1'b1}}) begin
        cycle_q <= cycle_q + CYCLE_W'(1);
      end
    end
  end

  // Dump bookkeeping: reads issued, reads in flight, words handed out
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt     <= '0;
      out_cnt    <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_issue;
      if (session_start) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd_issue)  rd_cnt  <= rd_cnt + 8'd1;
        if (dout_fire) out_cnt <= out_cnt + 8'd1;
      end
    end
  end

  boot_seq_dump_fifo u_dump_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_data (rdata_ext_2),
    .inflight  (rd_pending),
    .out_valid (dout_valid),
    .out_data  (dout_data),
    .out_ready (dout_ready),
    .credit    (credit)
  );

  assign addr_ext    = addr1_q;
  assign wen_ext     = wen1_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata1_q;
  assign addr_ext_2  = rd_issue ? (64'(rd_word) << DMEM_SHIFT) : addr2_q;
  assign wen_ext_2   = wen2_q;
  assign ren_ext_2   = rd_issue;
  assign wdata_ext_2 = wdata2_q;
  assign cpu_enable  = (state == ST_RUN);
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign done        = (state == ST_DONE);
  assign test_id     = test_id_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: a table of session records plus randomized
// sessions, each checked against expectations derived from the load images
// and the session parameters. A small memory model answers dmem reads.
module tb_boot_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_data;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        cpu_enable;
  logic [31:0] instr;
  logic [6:0]  dump_base;
  logic [7:0]  dump_len;
  logic        dout_valid;
  logic        dout_ready;
  logic [63:0] dout_data;
  logic        busy;
  logic        done;
  logic [3:0]  test_id;
  logic [31:0] cycle_count;
`ifdef BOOT_SEQ_WATCHDOG_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  boot_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .cpu_enable  (cpu_enable),
    .instr       (instr),
    .dump_base   (dump_base),
    .dump_len    (dump_len),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .busy        (busy),
    .done        (done),
    .test_id     (test_id),
    .cycle_count (cycle_count)
`ifdef BOOT_SEQ_WATCHDOG_EN
    ,
    .wd_limit    (32'hFFFF_FFFF),
    .timeout     (timeout)
`endif
  );

  typedef struct {
    logic [6:0]  base;
    logic [7:0]  len;
    int          stop_after;
    logic [31:0] stop_instr;
    bit          gap;
    int          stall;
    bit          rnd_ready;
    int          abort;       // 0 none, 1 reset in LOAD_I, 2 reset in RUN
    int          exp_cycles;
    logic [3:0]  exp_tid;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Session images and monitor state
  logic [63:0] dimg [128];
  logic [31:0] iimg [128];
  logic [63:0] dmem_m [128];
  logic [63:0] rd_stage;
  int d_wr = 0, i_wr = 0, wr_err = 0, overlap_err = 0, proto_err = 0, rd_total = 0;
  int rd_log [4096];
  int d_base = 0, i_base = 0, rd_base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model and protocol watcher, sampled after inputs settle
  always @(negedge clk) begin : mon
    int wi;
    #2;
    rd_stage = 64'hBAD0_BAD0_BAD0_BAD0;
    if (!rst) begin
      if (wen_ext_2) begin
        wi = d_wr - d_base;
        if (wi >= 128) wr_err++;
        else if (addr_ext_2 != (64'(wi) << 3) || wdata_ext_2 != dimg[wi]) wr_err++;
        dmem_m[addr_ext_2[9:3]] = wdata_ext_2;
        d_wr++;
      end
      if (wen_ext) begin
        wi = i_wr - i_base;
        if (wi >= 128) wr_err++;
        else if (addr_ext != (64'(wi) << 2) || wdata_ext != iimg[wi]) wr_err++;
        i_wr++;
      end
      if ((wen_ext | ren_ext) & (wen_ext_2 | ren_ext_2)) overlap_err++;
      if (ren_ext) proto_err++;
      if (ld_ready & (cpu_enable | done)) proto_err++;
      if (ren_ext_2) begin
        rd_log[rd_total % 4096] = int'(addr_ext_2[9:3]);
        rd_total++;
        rd_stage = dmem_m[addr_ext_2[9:3]];
      end
    end
  end

  always @(posedge clk) rdata_ext_2 <= rd_stage;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, cpu_enable, ld_ready, wen_ext, ren_ext, wen_ext_2,
                         ren_ext_2, dout_valid}), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    chk("rst_test_id", 64'(test_id), 64'd0);
    chk("rst_addr_ext", addr_ext, 64'd0);
    chk("rst_addr_ext_2", addr_ext_2, 64'd0);
    chk("rst_dout_data", dout_data, 64'd0);
    rst = 1'b0;
  endtask

  task automatic run_instr_cycle();
    logic [31:0] t;
    t = $urandom;
    if (t[6:0] == 7'h7E) t[0] = 1'b1;
    instr = t;
  endtask

  task automatic run_session(input vec_t v, input bit rand_img);
    int acc, cyc, busy_low, stab_err, wr0, ov0, pr0;
    logic [63:0] got [$];
    bit prev_stall;
    logic [63:0] prev_data;

    for (int i = 0; i < 128; i++) begin
      dimg[i] = rand_img ? {$urandom, $urandom} : 64'(i);
      iimg[i] = $urandom;
    end
    d_base = d_wr; i_base = i_wr; rd_base = rd_total;
    wr0 = wr_err; ov0 = overlap_err; pr0 = proto_err;
    instr = 32'h0000_0013;
    dout_ready = 1'b0;
    ld_valid = 1'b0;

    @(negedge clk);
    start = 1'b1; dump_base = v.base; dump_len = v.len;
    @(negedge clk);
    start = 1'b0; dump_base = 7'($urandom); dump_len = 8'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);

    // Load both images
    acc = 0; cyc = 0; busy_low = 0;
    while (acc < 256 && cyc < 2000) begin
      if (v.abort == 1 && acc == 138) break;
      ld_valid = v.gap ? (cyc % 2 == 0) : 1'b1;
      ld_data = (acc < 128) ? dimg[acc] : {$urandom, iimg[acc - 128]};
      if (!busy) busy_low++;
      if (ld_valid && ld_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    ld_valid = 1'b0;
    if (v.abort == 1) begin
      do_reset();
      return;
    end
    chk("load_beats", 64'(acc), 64'd256);
    chk("busy_load", 64'(busy_low), 64'd0);
    chk("settle_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("settle_ld_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    chk("run_rise", 64'(cpu_enable), 64'd1);
    chk("dmem_writes", 64'(d_wr - d_base), 64'd128);
    chk("imem_writes", 64'(i_wr - i_base), 64'd128);
    chk("write_content", 64'(wr_err - wr0), 64'd0);

    // Run until STOP
    if (v.abort == 2) begin
      for (int i = 0; i < 5; i++) begin run_instr_cycle(); @(negedge clk); end
      do_reset();
      return;
    end
    for (int i = 0; i < v.stop_after; i++) begin
      run_instr_cycle();
      @(negedge clk);
    end
    chk("stop_cycle_enable", 64'(cpu_enable), 64'd1);
    instr = v.stop_instr;
    @(negedge clk);
    instr = 32'h0000_0013;
    chk("enable_after_stop", 64'(cpu_enable), 64'd0);
    chk("cycle_count", 64'(cycle_count), 64'(v.exp_cycles));
    chk("test_id", 64'(test_id), 64'(v.exp_tid));
    chk("done_after_stop", 64'(done), 64'(v.len == 8'd0));

    // Collect the result window
    cyc = 0; stab_err = 0; prev_stall = 1'b0; prev_data = '0;
    while (!done && cyc < 3000) begin
      dout_ready = (cyc < v.stall) ? 1'b0 : (v.rnd_ready ? ($urandom % 4 != 0) : 1'b1);
      if (prev_stall && (!dout_valid || dout_data != prev_data)) stab_err++;
      if (dout_valid && dout_ready) got.push_back(dout_data);
      prev_stall = dout_valid && !dout_ready;
      prev_data = dout_data;
      @(negedge clk);
      cyc++;
    end
    dout_ready = 1'b0;
    chk("dump_done", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("dump_words", 64'(got.size()), 64'(v.len));
    for (int k = 0; k < got.size() && k < int'(v.len); k++)
      chk("dump_data", got[k], dimg[(int'(v.base) + k) % 128]);
    chk("read_count", 64'(rd_total - rd_base), 64'(v.len));
    for (int k = 0; k < rd_total - rd_base && k < int'(v.len); k++)
      chk("read_index", 64'(rd_log[(rd_base + k) % 4096]), 64'((int'(v.base) + k) % 128));
    chk("dout_stable", 64'(stab_err), 64'd0);
    chk("port_overlap", 64'(overlap_err - ov0), 64'd0);
    chk("port_protocol", 64'(proto_err - pr0), 64'd0);
  endtask

  vec_t tbl [6];

  initial begin
    vec_t v;
    logic [3:0] tid;

    tbl[0] = '{7'd35,  8'd12,  37, 32'h0000_007E, 1'b0, 10, 1'b0, 0, 37, 4'h0};
    tbl[1] = '{7'd126, 8'd4,    0, 32'h4000_007E, 1'b1,  0, 1'b1, 0,  0, 4'h4};
    tbl[2] = '{7'd0,   8'd0,    5, 32'h9000_007E, 1'b0,  0, 1'b0, 0,  5, 4'h9};
    tbl[3] = '{7'd3,   8'd2,    0, 32'h0000_007E, 1'b0,  0, 1'b0, 1,  0, 4'h0};
    tbl[4] = '{7'd3,   8'd2,    0, 32'h0000_007E, 1'b0,  0, 1'b0, 2,  0, 4'h0};
    tbl[5] = '{7'd10,  8'd128,  3, 32'h7ABC_DEFE, 1'b0,  3, 1'b1, 0,  3, 4'h7};

    start = 1'b0; ld_valid = 1'b0; ld_data = '0; instr = 32'h0000_0013;
    dump_base = '0; dump_len = '0; dout_ready = 1'b0;
    for (int i = 0; i < 128; i++) dmem_m[i] = '0;
    rd_stage = '0;
    @(negedge clk);
    do_reset();

    for (int t = 0; t < 6; t++) run_session(tbl[t], t != 0);

    for (int r = 0; r < 3; r++) begin
      tid = 4'($urandom);
      v.base = 7'($urandom);
      v.len = 8'($urandom % 24);
      v.stop_after = int'($urandom % 40);
      v.stop_instr = {tid, 21'($urandom), 7'h7E};
      v.gap = 1'($urandom);
      v.stall = int'($urandom % 6);
      v.rnd_ready = 1'b1;
      v.abort = 0;
      v.exp_cycles = v.stop_after;
      v.exp_tid = tid;
      run_session(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish before 1000000");
    $fatal(1, "bench timed out");
  end

endmodule
